// File: rtl/intt_addr_seq.sv
// Inverse-NTT address sequencer: walks layers 8..0 x 256 butterflies, issues read pairs
// and replays them as write-back pairs BF_LAT cycles later.
// Optional macro INTT_LAYER_DRAIN_EN: drain the butterfly pipeline between layers.
module intt_addr_seq #(
  parameter int unsigned BF_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [8:0] rd_addr_a,
  output logic [8:0] rd_addr_pair,
  output logic [3:0] rd_layer,
  output logic [7:0] rd_bf,
  output logic       wr_valid,
  output logic [8:0] wr_addr_a,
  output logic [8:0] wr_addr_pair,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DL_W = BF_LAT * 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              layer;
  logic [7:0]              bf;
  logic [4:0]              inflight;
  logic [4:0]              inflight_nxt;
  logic                    hs;
  logic                    bf_last;
  logic                    layer_last;
  logic [8:0]              base;
  logic [8:0]              offset;
  logic [8:0]              addr_a;
  logic [8:0]              addr_pair;
  logic [BF_LAT-1:0]       dl_v;
  logic [BF_LAT-1:0][17:0] dl_ap;

  // The 9-bit shift result provides the mod-512 wrap of the base term for free.
  always_comb begin
    base      = {bf, 1'b0} << layer;
    offset    = {1'b0, bf} >> (4'd8 - layer);
    addr_a    = base + offset;
    addr_pair = addr_a + (9'd1 << layer);
  end

  assign hs         = rd_valid & rd_ready;
  assign bf_last    = &bf;
  assign layer_last = (layer == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (hs && bf_last) begin
          if (layer_last) begin
            state_nxt = S_FLUSH;
          end else begin
`ifdef INTT_LAYER_DRAIN_EN
            state_nxt = S_DRAIN;
`else
            state_nxt = S_ISSUE;
`endif
          end
        end
      end
      // Looking at the post-update count lets the next state start in the cycle
      // right after the last write-back.
      S_DRAIN: begin
        if (inflight_nxt == 5'd0) state_nxt = S_ISSUE;
      end
      S_FLUSH: begin
        if (inflight_nxt == 5'd0) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_valid     = (state == S_ISSUE);
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    rd_addr_a    = rd_valid ? addr_a    : '0;
    rd_addr_pair = rd_valid ? addr_pair : '0;
    rd_layer     = rd_valid ? layer     : '0;
    rd_bf        = rd_valid ? bf        : '0;
    wr_valid     = dl_v[BF_LAT-1];
    wr_addr_a    = wr_valid ? dl_ap[BF_LAT-1][17:9] : '0;
    wr_addr_pair = wr_valid ? dl_ap[BF_LAT-1][8:0]  : '0;
  end

  always_comb begin
    inflight_nxt = inflight;
    if (hs && !wr_valid) begin
      inflight_nxt = inflight + 5'd1;
    end else if (!hs && wr_valid) begin
      inflight_nxt = inflight - 5'd1;
    end
  end

  // bf wraps to 0 on its own at the end of each layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer    <= 4'd8;
      bf       <= '0;
      inflight <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (state == S_IDLE && start) begin
        layer <= 4'd8;
        bf    <= '0;
      end else if (hs) begin
        bf <= bf + 8'd1;
        if (bf_last && !layer_last) layer <= layer - 4'd1;
      end
    end
  end

  // Stage 0 holds the newest entry; the oldest falls off the top of the cast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v  <= '0;
      dl_ap <= '0;
    end else begin
      dl_v  <= BF_LAT'({dl_v, hs});
      dl_ap <= DL_W'({dl_ap, addr_a, addr_pair});
    end
  end

endmodule

// File: tb/tb_intt_addr_seq.sv
// Directed bench for intt_addr_seq: spot-address table, full-transform timing,
// random stalls, mid-transform reset and ignored start pulses.
module tb_intt_addr_seq;

  localparam int unsigned BF_LAT = 4;
  localparam int N_HS = 2304;
`ifdef INTT_LAYER_DRAIN_EN
  localparam int GAP      = 5;
  localparam int L7_FIRST = 261;
  localparam int LAST_HS  = 2336;
  localparam int LAST_WR  = 2340;
  localparam int DONE_AT  = 2341;
`else
  localparam int GAP      = 1;
  localparam int L7_FIRST = 257;
  localparam int LAST_HS  = 2304;
  localparam int LAST_WR  = 2308;
  localparam int DONE_AT  = 2309;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [8:0] rd_addr_a;
  logic [8:0] rd_addr_pair;
  logic [3:0] rd_layer;
  logic [7:0] rd_bf;
  logic       wr_valid;
  logic [8:0] wr_addr_a;
  logic [8:0] wr_addr_pair;
  logic       busy;
  logic       done;

  intt_addr_seq #(.BF_LAT(BF_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_pair (rd_addr_pair),
    .rd_layer     (rd_layer),
    .rd_bf        (rd_bf),
    .wr_valid     (wr_valid),
    .wr_addr_a    (wr_addr_a),
    .wr_addr_pair (wr_addr_pair),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic check_le(input string name, input longint got, input longint lim);
    n_chk++;
    if (got <= lim) n_pass++;
    else $display("FAIL %s: got %0d, expected <= %0d", name, got, lim);
  endtask

  typedef struct {
    int layer;
    int bf;
    int a;
    int p;
  } vec_t;

  typedef struct {
    int t;
    int a;
    int p;
  } sb_t;

  vec_t vt [12];

  // Monitor state; cleared by the monitor itself whenever run_id changes.
  int  run_id = 0;
  int  seen_id = 0;
  bit  mon_on = 1'b0;
  int  base = 0;
  int  hs_cnt, wr_cnt, done_cnt, first_hs, last_hs, last_wr, done_at;
  int  first_busy, last_busy, l7_first, inflight, max_inflight;
  int  sb_err, gap_err, stab_err, addr_err, order_err, dup_err, cov_cnt;
  int  cur_layer, exp_bf;
  bit  prev_stall;
  logic [8:0] prev_a, prev_p;
  logic [3:0] prev_l;
  logic [7:0] prev_b;
  int  cap_a [N_HS];
  int  cap_p [N_HS];
  bit  cov [0:8][0:511];
  sb_t q [$];

  always @(negedge clk) begin
    int  rel;
    int  idx;
    sb_t e;
    if (run_id != seen_id) begin
      seen_id = run_id;
      hs_cnt = 0; wr_cnt = 0; done_cnt = 0; first_hs = -1; last_hs = 0;
      last_wr = -1; done_at = -1; first_busy = -1; last_busy = -1; l7_first = -1;
      inflight = 0; max_inflight = 0; sb_err = 0; gap_err = 0; stab_err = 0;
      addr_err = 0; order_err = 0; dup_err = 0; cov_cnt = 0;
      cur_layer = 8; exp_bf = 0; prev_stall = 1'b0;
      q.delete();
      for (int i = 0; i < N_HS; i++) begin
        cap_a[i] = -1;
        cap_p[i] = -1;
      end
      for (int l = 0; l < 9; l++)
        for (int x = 0; x < 512; x++) cov[l][x] = 1'b0;
    end
    if (mon_on && rst_n) begin
      rel = cyc - base + 1;
      if (busy) begin
        if (first_busy < 0) first_busy = rel;
        last_busy = rel;
      end
      if (prev_stall) begin
        if (!rd_valid || rd_addr_a != prev_a || rd_addr_pair != prev_p ||
            rd_layer != prev_l || rd_bf != prev_b) stab_err++;
      end
      if (rd_valid) begin
        if (int'(rd_layer) != cur_layer) begin
          if (int'(rd_layer) != cur_layer - 1 || rd_bf != 8'd0) order_err++;
          if (rel != last_hs + GAP) gap_err++;
          cur_layer = int'(rd_layer);
          exp_bf = 0;
        end
        if (rd_layer == 4'd7 && l7_first < 0) l7_first = rel;
      end
      if (rd_valid && rd_ready) begin
        hs_cnt++;
        last_hs = rel;
        if (first_hs < 0) first_hs = rel;
        if (int'(rd_bf) != exp_bf) order_err++;
        exp_bf++;
        if (int'(rd_addr_pair) != int'(rd_addr_a) + (1 << rd_layer)) addr_err++;
        if (rd_layer <= 4'd8) begin
          if (cov[rd_layer][rd_addr_a] || cov[rd_layer][rd_addr_pair]) dup_err++;
          cov[rd_layer][rd_addr_a] = 1'b1;
          cov[rd_layer][rd_addr_pair] = 1'b1;
          cov_cnt += 2;
          idx = int'(rd_layer) * 256 + int'(rd_bf);
          cap_a[idx] = int'(rd_addr_a);
          cap_p[idx] = int'(rd_addr_pair);
        end
        q.push_back('{rel, int'(rd_addr_a), int'(rd_addr_pair)});
        inflight++;
      end
      if (wr_valid) begin
        wr_cnt++;
        last_wr = rel;
        if (q.size() == 0) begin
          sb_err++;
        end else begin
          e = q.pop_front();
          if (e.t + int'(BF_LAT) != rel || e.a != int'(wr_addr_a) ||
              e.p != int'(wr_addr_pair)) sb_err++;
        end
        inflight--;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_at = rel;
      end
      if (inflight > max_inflight) max_inflight = inflight;
      prev_stall = rd_valid && !rd_ready;
      prev_a = rd_addr_a;
      prev_p = rd_addr_pair;
      prev_l = rd_layer;
      prev_b = rd_bf;
    end
  end

  function automatic longint out_vec();
    return longint'({rd_valid, wr_valid, busy, done, rd_addr_a, rd_addr_pair,
                     rd_layer, rd_bf, wr_addr_a, wr_addr_pair});
  endfunction

  task automatic run(input bit rnd, input bit inject);
    int k;
    int post;
    run_id++;
    start = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    mon_on = 1'b1;
    k = 0;
    post = 0;
    while (post < 12 && k < 6000) begin
      rd_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
      start = inject && (k == 300 || k == 1200 || done);
      @(posedge clk); #1;
      k++;
      if (done_cnt > 0) post++;
    end
    start = 1'b0;
    mon_on = 1'b0;
  endtask

  task automatic check_run(input bit exact, input string tag);
    check({tag, "_hs_count"}, hs_cnt, N_HS);
    check({tag, "_wr_count"}, wr_cnt, N_HS);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_first_busy"}, first_busy, 1);
    check({tag, "_last_busy"}, last_busy, done_at);
    check({tag, "_done_after_last_wr"}, done_at, last_wr + 1);
    check_le({tag, "_max_inflight"}, max_inflight, BF_LAT);
    check({tag, "_wr_delay_errors"}, sb_err, 0);
    check({tag, "_sb_leftover"}, q.size(), 0);
    check({tag, "_layer_gap_errors"}, gap_err, 0);
    check({tag, "_stall_stability_errors"}, stab_err, 0);
    check({tag, "_pair_offset_errors"}, addr_err, 0);
    check({tag, "_order_errors"}, order_err, 0);
    check({tag, "_dup_addr_errors"}, dup_err, 0);
    check({tag, "_coverage"}, cov_cnt, 9 * 512);
    if (exact) begin
      check({tag, "_first_hs"}, first_hs, 1);
      check({tag, "_l7_first"}, l7_first, L7_FIRST);
      check({tag, "_last_hs"}, last_hs, LAST_HS);
      check({tag, "_last_wr"}, last_wr, LAST_WR);
      check({tag, "_done_at"}, done_at, DONE_AT);
    end
  endtask

  task automatic reset_mid();
    int k;
    int stale;
    bit dropped;
    bit hit;
    run_id++;
    dropped = 1'b0;
    hit = 1'b0;
    start = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    mon_on = 1'b1;
    // Stall mid-layer 5 until one write-back drains, leaving three pairs in flight.
    for (k = 0; k < 3000 && !hit; k++) begin
      if (!dropped && rd_valid && rd_layer == 4'd5 && rd_bf >= 8'd100) begin
        rd_ready = 1'b0;
        dropped = 1'b1;
      end else if (dropped && inflight == 3) begin
        hit = 1'b1;
      end
      if (!hit) begin
        @(posedge clk); #1;
      end
    end
    check("rstmid_reached_3_inflight", hit, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_outputs_cleared", out_vec(), 0);
    mon_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_ready = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (wr_valid || rd_valid || busy || done) stale++;
    end
    check("rstmid_no_stale_activity", stale, 0);
  endtask

  initial begin
    vt[0]  = '{8,   0,   0, 256};
    vt[1]  = '{8,   1,   1, 257};
    vt[2]  = '{8, 255, 255, 511};
    vt[3]  = '{7,   0,   0, 128};
    vt[4]  = '{7,   1, 256, 384};
    vt[5]  = '{7,   3, 257, 385};
    vt[6]  = '{5, 100, 268, 300};
    vt[7]  = '{4, 200, 268, 284};
    vt[8]  = '{3,  37,  81,  89};
    vt[9]  = '{1,  10,  40,  42};
    vt[10] = '{0,   5,  10,  11};
    vt[11] = '{0, 255, 510, 511};

    #2;
    check("reset_outputs", out_vec(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", out_vec(), 0);
    @(posedge clk); #1;

    run(1'b0, 1'b0);
    check_run(1'b1, "full");
    for (int i = 0; i < 12; i++) begin
      check($sformatf("addr_a_L%0d_b%0d", vt[i].layer, vt[i].bf),
            cap_a[vt[i].layer * 256 + vt[i].bf], vt[i].a);
      check($sformatf("addr_pair_L%0d_b%0d", vt[i].layer, vt[i].bf),
            cap_p[vt[i].layer * 256 + vt[i].bf], vt[i].p);
    end

    run(1'b1, 1'b1);
    check_run(1'b0, "stall");

    reset_mid();
    run(1'b0, 1'b0);
    check_run(1'b1, "restart");
    check("restart_first_pair_a", cap_a[8 * 256], 0);
    check("restart_first_pair_p", cap_p[8 * 256], 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
